sll_iter_shifter: RTL and testbench
===================================

Name: sll_iter_shifter

Overview:
Multi-cycle logical shift-left unit, the left-direction counterpart of the arithmetic right shifter in the TP1 ALU datapath.
- Accepts operand A and shift amount B with a start/ready handshake.
- Shifts one bit per clock, then presents Z with a carry-out flag and a one-cycle done pulse.
- Used as the iterative SLL resource beside the combinational ALU ops.

Parameters:
W, 8, operand/result width in bits (W >= 4)
BW, 8, shift-amount width in bits

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when ready=1
A  input  W  operand to shift
B  input  BW  shift amount, unsigned
ready  output  1  high in IDLE; start accepted only when high
busy  output  1  high while an operation is in progress (not IDLE)
Z  output  W  result, registered; holds until the next completion
C  output  1  last bit shifted out of the MSB; 0 if no shift was performed
done  output  1  one-cycle pulse when Z/C are updated

Behaviour:
- Reset: rst_n low forces state=IDLE, acc=0, cnt=0, Z=0, C=0, done=0, busy=0, ready=1, immediately and asynchronously.
- Reset mid-operation aborts the operation; no done pulse; Z=0.
- State IDLE, ready=1, busy=0. On an edge with start=1:
  - acc <= A; cnt <= (B >= W) ? W : B.
  - Internal carry <= 0.
  - Next state SHIFT.
- State SHIFT, ready=0, busy=1. Each edge:
  - If cnt != 0: acc <= {acc[W-2:0],1'b0}; carry <= acc[W-1]; cnt <= cnt-1.
  - If cnt == 0: Z <= acc; C <= carry; done <= 1; next state IDLE.
- done is high for exactly one cycle. It is high in the first IDLE cycle, so a new start can be accepted on the same edge that done falls.
- Latency: with N = min(B,W), done is high in the cycle following edge t0+N+1, where t0 is the accepting edge.
  - B=0 gives Z=A, C=0 after 1 SHIFT cycle.
- Amounts >= W are saturated to W: Z=0, C=A[0].
- start while busy is ignored. A and B are not re-sampled during SHIFT; they may change freely.
- Z and C change only on completion or reset.
- Shift is logical: zero fill at the LSB, no sign handling.

Optional Feature:
Macro SLL_FAST_EN.
- Defined:
  - In SHIFT, when cnt >= 4: acc <= acc << 4; carry <= acc[W-4]; cnt <= cnt-4.
  - Otherwise the shift is single-bit as above.
  - Latency becomes floor(N/4) + (N mod 4) + 1 SHIFT cycles.
  - Result values Z and C are identical to the non-fast build.
- Not defined: strictly one bit per cycle. No extra logic is present.

Test Plan:
- Reset, then A=8'b00001011, B=1, start pulse → ready low next cycle; done pulses 2 cycles after the accepting edge; Z=8'b00010110, C=0, ready=1 again.
- A=8'h81, B=1 → Z=8'h02, C=1. Then A=8'hF0, B=4 → Z=8'h00, C=1, latency 5 cycles.
- B=0, A=8'h5A → Z=8'h5A, C=0, done after 1 SHIFT cycle. Also B=8 and B=200 with A=8'h01 → Z=8'h00, C=1, latency 9 for both (saturation).
- Back-to-back operations:
  - Start A=8'h03, B=3; change A/B and hold start=1 during busy → second request ignored until ready.
  - First result Z=8'h18.
  - Request held on the ready cycle is accepted immediately.
- Reset mid-operation: A=8'hFF, B=6, assert rst_n=0 after 3 cycles → Z=0, C=0, done=0 immediately, no done pulse after release, ready=1.
- SLL_FAST_EN defined: A=8'h0B, B=5 → Z=8'h60, C=1, done after 3 SHIFT cycles; B=8, A=8'h01 → Z=0, C=1 after 3 SHIFT cycles.

Source files
------------

// File: rtl/sll_iter_shifter.sv
// Multi-cycle logical shift-left unit: one bit per clock with start/ready handshake.
// Optional macro SLL_FAST_EN enables 4-bit strides while the remaining count is >= 4.
module sll_iter_shifter #(
    parameter int W  = 8,
    parameter int BW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [W-1:0]  A,
    input  logic [BW-1:0] B,
    output logic          ready,
    output logic          busy,
    output logic [W-1:0]  Z,
    output logic          C,
    output logic          done
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_acc;
    logic [CW-1:0]   r_cnt;
    logic            r_carry;
    logic [W-1:0]    r_z;
    logic            r_c;
    logic            r_done;
    logic            r_ready;
    logic            r_busy;

    logic            w_sat;
    logic [CW-1:0]   w_cnt_init;

    // Amounts of W or more leave nothing but the last-out bit, so clamp the count to W.
    assign w_sat      = (32'(B) >= 32'(W));
    assign w_cnt_init = w_sat ? CW'(W) : CW'(B);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_z     <= '0;
            r_c     <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc   <= A;
                        r_cnt   <= w_cnt_init;
                        r_carry <= 1'b0;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (r_cnt == '0) begin
                        r_z     <= r_acc;
                        r_c     <= r_carry;
                        r_done  <= 1'b1;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
`ifdef SLL_FAST_EN
                    else if (r_cnt >= CW'(4)) begin
                        r_acc   <= r_acc << 4;
                        r_carry <= r_acc[W-4];
                        r_cnt   <= r_cnt - CW'(4);
                    end
`endif
                    else begin
                        r_acc   <= {r_acc[W-2:0], 1'b0};
                        r_carry <= r_acc[W-1];
                        r_cnt   <= r_cnt - CW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ready = r_ready;
    assign busy  = r_busy;
    assign Z     = r_z;
    assign C     = r_c;
    assign done  = r_done;

endmodule

// File: tb/tb_sll_iter_shifter.sv
// Directed, table-driven bench for sll_iter_shifter (W=8, BW=8).
// Latency expectations follow SLL_FAST_EN when the macro is defined for the build.
module tb_sll_iter_shifter;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] A;
    logic [7:0] B;
    logic       ready;
    logic       busy;
    logic [7:0] Z;
    logic       C;
    logic       done;

    int n_vec;
    int n_fail;

    sll_iter_shifter #(.W(8), .BW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .ready (ready),
        .busy  (busy),
        .Z     (Z),
        .C     (C),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] z;
        logic       c;
        int         lat;
        int         lat_fast;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Wait for ready on a negedge, present the request, and let the next posedge accept it.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit hold_start);
        int k;
        @(negedge clk);
        k = 0;
        while (!ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("ready_before_start", 32'(ready), 32'd1);
        A = a;
        B = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold_start) start = 1'b0;
        check("ready_after_accept", 32'(ready), 32'd0);
        check("busy_after_accept", 32'(busy), 32'd1);
    endtask

    task automatic wait_done(output int lat);
        bit ok;
        lat = 0;
        ok  = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        check("done_within_bound", 32'(ok), 32'd1);
    endtask

    vec_t vecs[10];

    initial begin
        int lat;
        int exp_lat;
        int pulses;

        n_vec  = 0;
        n_fail = 0;
        start  = 1'b0;
        A      = '0;
        B      = '0;

        //          a      b       z      c     lat fast
        vecs[0] = '{8'h0B, 8'd1,   8'h16, 1'b0, 2, 2};
        vecs[1] = '{8'h81, 8'd1,   8'h02, 1'b1, 2, 2};
        vecs[2] = '{8'hF0, 8'd4,   8'h00, 1'b1, 5, 2};
        vecs[3] = '{8'h5A, 8'd0,   8'h5A, 1'b0, 1, 1};
        vecs[4] = '{8'h01, 8'd8,   8'h00, 1'b1, 9, 3};
        vecs[5] = '{8'h01, 8'd200, 8'h00, 1'b1, 9, 3};
        vecs[6] = '{8'h0B, 8'd5,   8'h60, 1'b1, 6, 3};
        vecs[7] = '{8'hA5, 8'd3,   8'h28, 1'b1, 4, 4};
        vecs[8] = '{8'h80, 8'd7,   8'h00, 1'b0, 8, 5};
        vecs[9] = '{8'h3C, 8'd2,   8'hF0, 1'b0, 3, 3};

        rst_n = 1'b0;
        #12;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_z",     32'(Z),     32'd0);
        check("rst_c",     32'(C),     32'd0);
        check("rst_done",  32'(done),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
`ifdef SLL_FAST_EN
            exp_lat = vecs[i].lat_fast;
`else
            exp_lat = vecs[i].lat;
`endif
            run_op(vecs[i].a, vecs[i].b, 1'b0);
            wait_done(lat);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(exp_lat));
            check($sformatf("v%0d_z", i), 32'(Z), 32'(vecs[i].z));
            check($sformatf("v%0d_c", i), 32'(C), 32'(vecs[i].c));
            check($sformatf("v%0d_ready_at_done", i), 32'(ready), 32'd1);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_done_one_cycle", i), 32'(done), 32'd0);
            check($sformatf("v%0d_z_hold", i), 32'(Z), 32'(vecs[i].z));
        end

        // Back-to-back: start held high throughout, operands changed while busy.
        run_op(8'h03, 8'd3, 1'b1);
        A = 8'hC1;
        B = 8'd2;
        wait_done(lat);
        check("b2b_first_latency", 32'(lat), 32'd4);
        check("b2b_first_z", 32'(Z), 32'h18);
        check("b2b_first_c", 32'(C), 32'd0);
        check("b2b_ready_at_done", 32'(ready), 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_second_accepted", 32'(ready), 32'd0);
        check("b2b_done_fell", 32'(done), 32'd0);
        wait_done(lat);
        check("b2b_second_latency", 32'(lat), 32'd3);
        check("b2b_second_z", 32'(Z), 32'h04);
        check("b2b_second_c", 32'(C), 32'd1);

        // Reset mid-operation aborts and clears outputs asynchronously.
        run_op(8'hFF, 8'd6, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_z", 32'(Z), 32'd0);
        check("abort_c", 32'(C), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("abort_no_done", 32'(pulses), 32'd0);
        check("abort_ready_after", 32'(ready), 32'd1);
        check("abort_z_after", 32'(Z), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
